// File: rtl/squeeze_output_unit.sv
// Streams the rate lanes of the permuted Keccak state as 64-bit beats and requests a new permutation when a rate block runs out.
// The first beat is valid the cycle after state_valid_i, then one beat per cycle; outputs hold while ready_i is low.
module squeeze_output_unit #(
  parameter int OUT_LEN_WIDTH = 16,
  parameter int ROW_SIZE      = 5,
  parameter int COL_SIZE      = 5,
  parameter int LANE_SIZE     = 64,
  parameter int RATE_WIDTH    = 11
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           start_i,
  input  logic [RATE_WIDTH-1:0]                          rate_i,
  input  logic [OUT_LEN_WIDTH-1:0]                       out_len_i,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_i,
  input  logic                                           state_valid_i,
  output logic                                           perm_req_o,
  output logic [63:0]                                    data_o,
  output logic [7:0]                                     keep_o,
  output logic                                           valid_o,
  output logic                                           last_o,
  input  logic                                           ready_i,
  output logic                                           busy_o,
  output logic                                           done_o
);

  localparam int NUM_LANES = ROW_SIZE * COL_SIZE;
  localparam int LIDX_W    = $clog2(NUM_LANES);
  localparam logic [LIDX_W-1:0]        LIDX_ONE  = LIDX_W'(1);
  localparam logic [OUT_LEN_WIDTH-1:0] LANE_BYTES = OUT_LEN_WIDTH'(8);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_STATE = 2'd1,
    SQUEEZE    = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [LIDX_W-1:0]        lane_idx_q, lane_idx_d;
  logic [LIDX_W-1:0]        rate_lanes_q, rate_lanes_d;
  logic [OUT_LEN_WIDTH-1:0] bytes_rem_q, bytes_rem_d;
  logic                     perm_req_q, perm_req_d;
  logic                     done_q, done_d;

  // Flatten the state so lane i sits at x = i % 5, y = i / 5.
  logic [NUM_LANES-1:0][LANE_SIZE-1:0] lanes;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lanes[i] = state_array_i[i % ROW_SIZE][i / ROW_SIZE];
  end

  logic [LANE_SIZE-1:0] lane_sel;
  assign lane_sel = lanes[lane_idx_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lane_idx_q   <= '0;
      rate_lanes_q <= '0;
      bytes_rem_q  <= '0;
      perm_req_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_idx_q   <= lane_idx_d;
      rate_lanes_q <= rate_lanes_d;
      bytes_rem_q  <= bytes_rem_d;
      perm_req_q   <= perm_req_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    valid_o = 1'b0;
    last_o  = 1'b0;
    keep_o  = '0;
    data_o  = '0;
    if (state_q == SQUEEZE) begin
      valid_o = 1'b1;
      last_o  = (bytes_rem_q <= LANE_BYTES);
      for (int k = 0; k < 8; k++) begin
        keep_o[k]       = (bytes_rem_q > OUT_LEN_WIDTH'(k));
        data_o[8*k +: 8] = keep_o[k] ? lane_sel[8*k +: 8] : 8'h00;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    lane_idx_d   = lane_idx_q;
    rate_lanes_d = rate_lanes_q;
    bytes_rem_d  = bytes_rem_q;
    perm_req_d   = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (out_len_i != '0) begin
            rate_lanes_d = LIDX_W'(rate_i >> 6);
            bytes_rem_d  = out_len_i;
            lane_idx_d   = '0;
            state_d      = WAIT_STATE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT_STATE: begin
        // A state_valid_i coinciding with our own request still refers to the old state.
        if (state_valid_i && !perm_req_q) begin
          state_d = SQUEEZE;
        end
      end
      SQUEEZE: begin
        if (ready_i) begin
          if (bytes_rem_q <= LANE_BYTES) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (lane_idx_q == rate_lanes_q - LIDX_ONE) begin
            bytes_rem_d = bytes_rem_q - LANE_BYTES;
            lane_idx_d  = '0;
            perm_req_d  = 1'b1;
            state_d     = WAIT_STATE;
          end else begin
            bytes_rem_d = bytes_rem_q - LANE_BYTES;
            lane_idx_d  = lane_idx_q + LIDX_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign perm_req_o = perm_req_q;
  assign done_o     = done_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_squeeze_output_unit.sv
// Randomized squeeze runs against a byte-stream reference model, plus directed reset and zero-length cases.
module tb_squeeze_output_unit;

  typedef logic [4:0][4:0][63:0] state_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [10:0] rate_i;
  logic [15:0] out_len_i;
  state_t      state_array_i;
  logic        state_valid_i;
  logic        perm_req_o;
  logic [63:0] data_o;
  logic [7:0]  keep_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  squeeze_output_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .rate_i        (rate_i),
    .out_len_i     (out_len_i),
    .state_array_i (state_array_i),
    .state_valid_i (state_valid_i),
    .perm_req_o    (perm_req_o),
    .data_o        (data_o),
    .keep_o        (keep_o),
    .valid_o       (valid_o),
    .last_o        (last_o),
    .ready_i       (ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_last"},  64'(last_o), 64'd0);
    chk({tag, "_perm"},  64'(perm_req_o), 64'd0);
    chk({tag, "_busy"},  64'(busy_o), 64'd0);
    chk({tag, "_done"},  64'(done_o), 64'd0);
    chk({tag, "_data"},  data_o, 64'd0);
    chk({tag, "_keep"},  64'(keep_o), 64'd0);
  endtask

  // Model: output is the byte stream of rate lanes 0..nl-1 of block 0, then block 1, ...
  // truncated to len bytes; beats are 8-byte slices of that stream.
  task automatic run_case(input string nm, input int rate, input int len, input int stall_pct,
                          input int stall_at, input bit poke_perm, input bit poke_start,
                          input int rst_at);
    int nl, nbeats, nblocks, beat, perms, wait_cnt, stall_cnt, nbytes, li, blk;
    bit fin, exp_valid, did_rst;
    state_t blocks[$];
    logic [63:0] lane, exp_data;
    logic [7:0]  exp_keep;

    nl      = rate / 64;
    nbeats  = (len + 7) / 8;
    nblocks = (nbeats + nl - 1) / nl;
    for (int b = 0; b < nblocks; b++) begin
      state_t s;
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          s[x][y] = {$urandom, $urandom};
      blocks.push_back(s);
    end

    @(negedge clk);
    rate_i    = 11'(rate);
    out_len_i = 16'(len);
    start_i   = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
    beat = 0; perms = 0; wait_cnt = 2; stall_cnt = 0;
    fin = 1'b0; exp_valid = 1'b0; did_rst = 1'b0;

    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (beat == stall_at && stall_cnt < 3) begin
        ready_i = 1'b0;
        stall_cnt++;
      end else begin
        ready_i = ($urandom_range(99) >= stall_pct);
      end
      start_i = poke_start && (cyc == 0 || cyc == 4);
      if (start_i) out_len_i = 16'd8;

      if (exp_valid) chk({nm, "_first_latency"}, 64'(valid_o), 64'd1);
      exp_valid = 1'b0;

      if (valid_o) begin
        if (beat < nbeats) begin
          blk    = beat / nl;
          li     = beat % nl;
          lane   = blocks[blk][li % 5][li / 5];
          nbytes = len - 8 * beat;
          if (nbytes > 8) nbytes = 8;
          exp_keep = 8'((1 << nbytes) - 1);
          exp_data = '0;
          for (int k = 0; k < nbytes; k++) exp_data[8*k +: 8] = lane[8*k +: 8];
          chk($sformatf("%s_data_b%0d", nm, beat), data_o, exp_data);
          chk($sformatf("%s_keep_b%0d", nm, beat), 64'(keep_o), 64'(exp_keep));
          chk($sformatf("%s_last_b%0d", nm, beat), 64'(last_o), 64'(beat == nbeats - 1));
          if (beat == rst_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            chk_idle_outputs({nm, "_after_rst"});
            rst_n = 1'b1;
            ready_i = 1'b1;
            repeat (3) begin
              @(negedge clk);
              chk({nm, "_no_done_after_rst"}, 64'(done_o), 64'd0);
            end
            did_rst = 1'b1;
            break;
          end
          if (ready_i) beat++;
        end else begin
          chk({nm, "_extra_beat"}, 64'(valid_o), 64'd0);
        end
      end

      state_valid_i = 1'b0;
      if (perm_req_o) begin
        perms++;
        chk($sformatf("%s_perm_at_beat%0d", nm, beat), 64'(beat), 64'(perms * nl));
        state_valid_i = poke_perm;
        wait_cnt = 3;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          if (perms < nblocks) state_array_i = blocks[perms];
          state_valid_i = 1'b1;
          exp_valid = 1'b1;
        end
      end

      if (done_o) begin
        chk({nm, "_done_beats"}, 64'(beat), 64'(nbeats));
        chk({nm, "_perm_count"}, 64'(perms), 64'(nblocks - 1));
        state_valid_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk({nm, "_done_pulse"}, 64'(done_o), 64'd0);
        chk({nm, "_busy_end"},   64'(busy_o), 64'd0);
        fin = 1'b1;
      end
      if (!fin) @(negedge clk);
    end
    if (!fin && !did_rst) chk({nm, "_timeout"}, 64'd1, 64'd0);
    start_i       = 1'b0;
    state_valid_i = 1'b0;
  endtask

  initial begin
    int rates[5];
    rates = '{576, 832, 1088, 1152, 1344};
    rst_n = 1'b0; start_i = 1'b0; rate_i = '0; out_len_i = '0;
    state_array_i = '0; state_valid_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    run_case("t1_32B",      1088, 32,  0,  -1, 1'b0, 1'b0, -1);
    run_case("t2_13B",      1088, 13,  0,  -1, 1'b0, 1'b0, -1);
    run_case("t3_200B",     1344, 200, 0,  -1, 1'b1, 1'b0, -1);
    run_case("t4_136B",     1088, 136, 0,  -1, 1'b0, 1'b0, -1);

    @(negedge clk);
    out_len_i = 16'd0; rate_i = 11'd1088; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("zero_len_done",  64'(done_o), 64'd1);
    chk("zero_len_valid", 64'(valid_o), 64'd0);
    chk("zero_len_busy",  64'(busy_o), 64'd0);
    @(negedge clk);
    chk("zero_len_done_drop", 64'(done_o), 64'd0);
    chk("zero_len_valid2",    64'(valid_o), 64'd0);

    run_case("t5_stall",    1088, 100, 20, 3,  1'b0, 1'b0, -1);
    run_case("t6_rst",      1088, 64,  0,  -1, 1'b0, 1'b0, 4);
    run_case("t6_busy_start", 1344, 50, 0, -1, 1'b0, 1'b1, -1);
    run_case("rate_edge_576", 576, 144, 10, -1, 1'b1, 1'b0, -1);

    for (int i = 0; i < 4; i++) begin
      run_case($sformatf("rand%0d", i), rates[$urandom_range(4)],
               int'($urandom_range(300, 1)), 25, int'($urandom_range(5)), 1'b1, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
